if_pc_gen: RTL
==============

Name: if_pc_gen

Overview:
- PC generation and instruction-fetch front end of the five-stage RISC-V core.
- Sits directly upstream of the IF/ID pipeline register. Its pc_o/inst_o drive that register's pc_i/inst_i.
- Holds the fetch PC and applies redirects from EX.
- Runs a single-outstanding req/gnt/rvalid handshake to instruction memory.
- Buffers one response so a stalled IF/ID never loses an instruction.

Parameters:
- XLEN, 32 (from defines.v `XLEN): datapath/address width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INST, 32'h0000_0013: addi x0,x0,0, driven on inst_o when no valid instruction.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- rst_i  input  1  reset. Synchronous, active-low: reset is applied when rst_i==0 at posedge clk_i.
- stall_i  input  1  from pipectrl; IF/ID holds, so the current output is not consumed.
- redirect_i  input  1  from EX; one-cycle pulse for a taken branch/jump.
- redirect_pc_i  input  XLEN  target PC, valid with redirect_i.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  XLEN  fetch address; stable while imem_req_o is high.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid; at least 1 cycle after gnt.
- imem_rdata_i  input  XLEN  fetched instruction.
- pc_o  output  XLEN  PC of inst_o; to IF/ID.
- inst_o  output  XLEN  instruction; to IF/ID.
- valid_o  output  1  pc_o/inst_o hold a real instruction.

Behaviour:
- Reset values (rst_i==0): state=IDLE, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, inst_o=NOP_INST, valid_o=0, skid empty, kill=0.
- Reset mid-transaction: any in-flight response arriving after reset is ignored, because kill/WAIT state is cleared and rvalid is ignored outside WAIT.
- Output consumption: the output is consumed in any cycle with valid_o=1 and stall_i=0.
- Output slot free: valid_o=0, or consumed this cycle.
- FSM states:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_o=1, imem_addr_o=fetch_pc. Entered only when the skid is empty. On gnt -> WAIT.
  - WAIT: imem_req_o=0. On rvalid:
    - If kill=1: discard, clear kill, go to REQ.
    - Else if the slot is free: load pc_o/inst_o, set valid_o=1, fetch_pc+=4, go to REQ.
    - Else: load skid, fetch_pc+=4, go to DRAIN.
  - DRAIN: wait until the slot is free, move skid to the output, go to REQ.
- Throughput: at most one instruction per 2 cycles with a zero-wait memory (REQ+gnt, then WAIT+rvalid). inst_o is updated on the edge that samples rvalid.
- Redirect (highest priority, including over stall_i):
  - fetch_pc <= {redirect_pc_i[XLEN-1:2],2'b00}.
  - valid_o <= 0, inst_o <= NOP_INST; skid cleared.
  - In REQ without gnt: go to REQ with the new address next cycle.
  - In REQ with gnt, or in WAIT without rvalid: set kill, go to / stay in WAIT.
  - In WAIT with rvalid in the same cycle: discard the data, go to REQ.
  - In DRAIN: go to REQ.
- Consumed with no new data: valid_o <= 0 and inst_o <= NOP_INST. pc_o holds.
- PC arithmetic: modulo 2^XLEN. 32'hFFFF_FFFC+4 wraps to 0.
- imem_addr_o[1:0] is always 2'b00.

Optional Feature:
- Macro: IF_PC_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 and sends the FSM to IDLE, with no fetch issued.
  - misalign_o and the IDLE hold persist until the next redirect (target aligned) or reset.
- Undefined: the port is absent; the low 2 bits are silently cleared.

Decomposition:
- Package if_pkg holds:
  - NOP_INST value.
  - FSM state typedef (IDLE, REQ, WAIT, DRAIN; 2-bit encoding).
  - PC increment constant (4).
- XLEN stays in defines.v.
- Sub-module if_skid_buf: one-entry {pc,inst} buffer with load/drain/flush and a full flag.

Test Plan:
- Reset release, zero-wait memory (gnt with req, rvalid next cycle), stall_i=0:
  - Addresses 0x0, 0x4, 0x8 are issued.
  - pc_o/inst_o update every 2 cycles.
  - valid_o pulses each time.
- stall_i held high 5 cycles from when valid_o=1 with PC 0x4:
  - pc_o=0x4 holds.
  - Response for 0x8 goes to the skid.
  - No request is issued while the skid is full.
  - When stall drops: output 0x8 follows 0x4; next request is 0xC.
- redirect_i with redirect_pc_i=0x100 in the WAIT cycle before rvalid of 0x8:
  - 0x8 data is discarded.
  - Next imem_addr_o=0x100.
  - No valid_o for 0x8 appears.
- redirect_i coincident with rvalid, and coincident with stall_i=1 and full skid:
  - Output flushes to NOP_INST with valid_o=0.
  - Next fetch is the target.
- redirect_pc_i=0xFFFF_FFFC:
  - Fetches 0xFFFF_FFFC, then 0x0000_0000.
- rst_i driven low while in WAIT, then rvalid arrives:
  - All outputs return to reset values.
  - The stale rvalid is ignored.
  - First fetch after release is RESET_PC.
- (IF_PC_MISALIGN_CHK_EN) redirect to 0x102:
  - misalign_o=1 and no request issued.
  - A subsequent redirect to 0x200 clears misalign_o and fetches 0x200.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared constants and FSM state type for the instruction-fetch front end
package if_pkg;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] PC_INC = 32'd4;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} if_state_e;
endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry {pc,inst} holding buffer for a response that IF/ID cannot take yet
//   clk_i/rst_i       clock, synchronous active-low reset
//   load_i            capture pc_i/inst_i and mark full
//   drain_i           entry handed to the output, mark empty
//   flush_i           discard the entry (redirect), wins over load/drain
//   full_o/pc_o/inst_o  buffer status and contents
module if_skid_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            drain_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] inst_i,
   output logic            full_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o
);
   logic            full_q;
   logic [XLEN-1:0] pc_q, inst_q;
   always_ff @(posedge clk_i) begin
      if (!rst_i || flush_i) full_q <= 1'b0;
      else if (load_i) full_q <= 1'b1;
      else if (drain_i) full_q <= 1'b0;
      if (load_i) begin
         pc_q   <= pc_i;
         inst_q <= inst_i;
      end
   end
   assign full_o = full_q;
   assign pc_o   = pc_q;
   assign inst_o = inst_q;
endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch PC generator with single-outstanding imem handshake feeding IF/ID
//   clk_i/rst_i               clock, synchronous active-low reset
//   stall_i                   IF/ID holding, current output not consumed
//   redirect_i/redirect_pc_i  taken branch/jump target from EX (one-cycle pulse)
//   imem_req_o/imem_addr_o    fetch request and word-aligned address
//   imem_gnt_i/imem_rvalid_i/imem_rdata_i  memory accept and response
//   pc_o/inst_o/valid_o       fetched instruction towards IF/ID
//   misalign_o                present only with IF_PC_MISALIGN_CHK_EN: sticky misaligned-target flag
module if_pc_gen
   import if_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] inst_o,
`ifdef IF_PC_MISALIGN_CHK_EN
   output logic            misalign_o,
`endif
   output logic            valid_o
);
   if_state_e       state_q;
   logic [XLEN-1:0] fetch_pc_q, pc_q, inst_q, skid_pc, skid_inst;
   logic            kill_q, valid_q, skid_full, free, take, pop, redir_kill;
   assign free = !valid_q || !stall_i;
   // response accepted into the pipeline (output slot or skid)
   assign take = state_q == WAIT && imem_rvalid_i && !kill_q && !redirect_i;
   assign pop = state_q == DRAIN && skid_full && free && !redirect_i;
   // a granted request whose response is still to come must be discarded after a redirect
   assign redir_kill = (state_q == REQ && imem_gnt_i) || (state_q == WAIT && !imem_rvalid_i);
   if_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(take && !free), .drain_i(pop), .flush_i(redirect_i),
      .pc_i(fetch_pc_q), .inst_i(imem_rdata_i), .full_o(skid_full), .pc_o(skid_pc), .inst_o(skid_inst)
   );
`ifdef IF_PC_MISALIGN_CHK_EN
   logic misalign_q;
   assign misalign_o = misalign_q;
`endif
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
         pc_q       <= '0;
         inst_q     <= XLEN'(NOP_INST);
         valid_q    <= 1'b0;
`ifdef IF_PC_MISALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else if (redirect_i) begin
         fetch_pc_q <= redirect_pc_i & ~XLEN'(3);
         valid_q    <= 1'b0;
         inst_q     <= XLEN'(NOP_INST);
         kill_q     <= redir_kill;
         state_q    <= redir_kill ? WAIT : REQ;
`ifdef IF_PC_MISALIGN_CHK_EN
         misalign_q <= |redirect_pc_i[1:0];
         if (|redirect_pc_i[1:0]) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
         end
`endif
      end else begin
         if (valid_q && !stall_i) begin
            valid_q <= 1'b0;
            inst_q  <= XLEN'(NOP_INST);
         end
         if ((take && free) || pop) begin
            pc_q    <= take ? fetch_pc_q : skid_pc;
            inst_q  <= take ? imem_rdata_i : skid_inst;
            valid_q <= 1'b1;
         end
         if (take) fetch_pc_q <= fetch_pc_q + XLEN'(PC_INC);
         case (state_q)
`ifdef IF_PC_MISALIGN_CHK_EN
            IDLE:    state_q <= misalign_q ? IDLE : REQ;
`else
            IDLE:    state_q <= REQ;
`endif
            REQ:     state_q <= imem_gnt_i ? WAIT : REQ;
            WAIT: begin
               if (imem_rvalid_i) begin
                  kill_q  <= 1'b0;
                  state_q <= (kill_q || free) ? REQ : DRAIN;
               end
            end
            DRAIN:   state_q <= pop ? REQ : DRAIN;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign imem_req_o  = state_q == REQ;
   assign imem_addr_o = fetch_pc_q;
   assign pc_o        = pc_q;
   assign inst_o      = inst_q;
   assign valid_o     = valid_q;
endmodule
